// File: rtl/fitness_eval_ctrl.sv
// Serial fitness sequencer: holds one chromosome on the phenotype and sweeps every input vector.
// It counts the output bits that match the target truth table and reports the total as the fitness.
module fitness_eval_ctrl #(
    parameter int IN      = 4,
    parameter int OUT     = 2,
    parameter int CHROM_W = 64,
    localparam int TGT_W  = OUT * 2**IN,
    localparam int FIT_W  = $clog2(OUT * 2**IN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CHROM_W-1:0] chrom_in,
    input  logic [TGT_W-1:0]   target_in,
    output logic [CHROM_W-1:0] phen_chrom,
    output logic [IN-1:0]      phen_inp,
    input  logic [OUT-1:0]     phen_out,
    output logic               busy,
    output logic               done,
    output logic [FIT_W-1:0]   fitness,
    output logic               perfect
);

    localparam int N = 2**IN;
    localparam logic [IN-1:0]    LAST_IDX = IN'(N - 1);
    localparam logic [FIT_W-1:0] MAX_FIT  = FIT_W'(OUT * N);

    typedef enum logic [1:0] {IDLE, EVAL, DRAIN, DONE} state_t;

    state_t             state;
    logic [TGT_W-1:0]   tgt;
    logic [OUT-1:0]     cap_out;
    logic [IN-1:0]      cap_idx;
    logic               cap_valid;
    logic [FIT_W-1:0]   acc;

    logic [TGT_W-1:0]   tgt_shift;
    logic [OUT-1:0]     tgt_slice;
    logic [OUT-1:0]     match_bits;
    logic [FIT_W-1:0]   match_cnt;
    logic [FIT_W-1:0]   acc_next;

    // Scoring stage works on the vector captured one edge earlier.
    // Capturing first keeps the phenotype's settling path apart from the adder.
    always_comb begin
        tgt_shift  = tgt >> (int'(cap_idx) * OUT);
        tgt_slice  = tgt_shift[OUT-1:0];
        match_bits = ~(cap_out ^ tgt_slice);
        match_cnt  = '0;
        for (int i = 0; i < OUT; i++) begin
            match_cnt = match_cnt + FIT_W'(match_bits[i]);
        end
        acc_next = cap_valid ? acc + match_cnt : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            phen_chrom <= '0;
            phen_inp   <= '0;
            tgt        <= '0;
            cap_out    <= '0;
            cap_idx    <= '0;
            cap_valid  <= 1'b0;
            acc        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fitness    <= '0;
            perfect    <= 1'b0;
        end else begin
            acc <= acc_next;
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        phen_chrom <= chrom_in;
                        tgt        <= target_in;
                        phen_inp   <= '0;
                        acc        <= '0;
                        cap_valid  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EVAL;
                    end else begin
                        state <= IDLE;
                    end
                end
                EVAL: begin
                    cap_out   <= phen_out;
                    cap_idx   <= phen_inp;
                    cap_valid <= 1'b1;
                    if (phen_inp == LAST_IDX) begin
                        state <= DRAIN;
                    end else begin
                        phen_inp <= phen_inp + IN'(1);
                    end
                end
                DRAIN: begin
                    fitness   <= acc_next;
                    perfect   <= (acc_next == MAX_FIT);
                    cap_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// Directed bench for fitness_eval_ctrl with stub phenotypes: a 1-output build and a 2-output build.
module tb_fitness_eval_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] chrom_in;
    logic [3:0] target_in;
    logic [3:0] phen_chrom;
    logic [1:0] phen_inp;
    logic       phen_out;
    logic       busy;
    logic       done;
    logic [2:0] fitness;
    logic       perfect;

    logic       start2;
    logic [7:0] chrom_in2;
    logic [7:0] target_in2;
    logic [7:0] phen_chrom2;
    logic [1:0] phen_inp2;
    logic [1:0] phen_out2;
    logic [7:0] chrom2_shift;
    logic       busy2;
    logic       done2;
    logic [3:0] fitness2;
    logic       perfect2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign phen_out     = phen_chrom[phen_inp];
    assign chrom2_shift = phen_chrom2 >> {phen_inp2, 1'b0};
    assign phen_out2    = chrom2_shift[1:0];

    fitness_eval_ctrl #(.IN(2), .OUT(1), .CHROM_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .chrom_in(chrom_in), .target_in(target_in),
        .phen_chrom(phen_chrom), .phen_inp(phen_inp), .phen_out(phen_out),
        .busy(busy), .done(done), .fitness(fitness), .perfect(perfect)
    );

    fitness_eval_ctrl #(.IN(2), .OUT(2), .CHROM_W(8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .chrom_in(chrom_in2), .target_in(target_in2),
        .phen_chrom(phen_chrom2), .phen_inp(phen_inp2), .phen_out(phen_out2),
        .busy(busy2), .done(done2), .fitness(fitness2), .perfect(perfect2)
    );

    typedef struct {
        logic [3:0] chrom;
        logic [3:0] target;
        int         fit;
        logic       perf;
        bit         check_seq;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One full evaluation on the 1-output build; it returns to IDLE afterwards.
    task automatic apply_stimulus(input vec_t v);
        int lat;
        int busy_cnt;
        chrom_in  = v.chrom;
        target_in = v.target;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        chrom_in  = ~v.chrom;
        target_in = ~v.target;
        check_output("chrom_latched", int'(phen_chrom), int'(v.chrom));
        lat = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (v.check_seq && lat <= 4)
                check_output($sformatf("phen_inp_k%0d", lat), int'(phen_inp), (lat < 3) ? lat : 3);
            if (busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
        check_output("done_seen", int'(done), 1);
        check_output("latency", lat, 5);
        check_output("fitness", int'(fitness), v.fit);
        check_output("perfect", int'(perfect), int'(v.perf));
        check_output("busy_in_done", int'(busy), 0);
        if (v.check_seq) check_output("busy_cycles", busy_cnt, 5);
        tick();
        check_output("done_one_cycle", int'(done), 0);
        check_output("fitness_hold", int'(fitness), v.fit);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check_output("done_seen", int'(done), 1);
    endtask

    task automatic run_out2(input logic [7:0] c, input logic [7:0] t, input int exp_fit, input int exp_perf);
        int lat;
        chrom_in2  = c;
        target_in2 = t;
        start2     = 1'b1;
        tick();
        start2     = 1'b0;
        lat = 0;
        while (done2 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check_output("out2_done_seen", int'(done2), 1);
        check_output("out2_latency", lat, 5);
        check_output("out2_fitness", int'(fitness2), exp_fit);
        check_output("out2_perfect", int'(perfect2), exp_perf);
        tick();
    endtask

    initial begin
        int lat;
        vecs[0] = '{4'b0110, 4'b0110, 4, 1'b1, 1'b1};
        vecs[1] = '{4'b0110, 4'b1001, 0, 1'b0, 1'b0};
        vecs[2] = '{4'b0111, 4'b0110, 3, 1'b0, 1'b0};
        vecs[3] = '{4'b1010, 4'b1000, 3, 1'b0, 1'b1};
        vecs[4] = '{4'b0000, 4'b0000, 4, 1'b1, 1'b0};
        vecs[5] = '{4'b1111, 4'b0000, 0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; chrom_in = '0; target_in = '0;
        start2 = 1'b0; chrom_in2 = '0; target_in2 = '0;
        tick();
        tick();
        rst = 1'b0;
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_done", int'(done), 0);
        check_output("rst_fitness", int'(fitness), 0);
        check_output("rst_perfect", int'(perfect), 0);
        check_output("rst_phen_inp", int'(phen_inp), 0);
        check_output("rst_phen_chrom", int'(phen_chrom), 0);

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Back-to-back: start held high, second operands accepted in the DONE cycle.
        chrom_in = 4'b0110; target_in = 4'b0110; start = 1'b1;
        tick();
        chrom_in = 4'b1001; target_in = 4'b0110;
        wait_done(lat);
        check_output("b2b_lat1", lat, 5);
        check_output("b2b_fit1", int'(fitness), 4);
        check_output("b2b_perf1", int'(perfect), 1);
        tick();
        start = 1'b0;
        check_output("b2b_phen_inp0", int'(phen_inp), 0);
        check_output("b2b_busy", int'(busy), 1);
        check_output("b2b_done_low", int'(done), 0);
        check_output("b2b_chrom2", int'(phen_chrom), 9);
        check_output("b2b_fit_kept", int'(fitness), 4);
        wait_done(lat);
        check_output("b2b_lat2", lat, 5);
        check_output("b2b_fit2", int'(fitness), 0);
        check_output("b2b_perf2", int'(perfect), 0);
        tick();

        // start pulses while busy must be ignored.
        chrom_in = 4'b0111; target_in = 4'b0110; start = 1'b1;
        tick();
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            chrom_in = 4'b1111; target_in = 4'b0000; start = 1'b1;
            check_output("ign_chrom", int'(phen_chrom), 7);
            tick();
            lat++;
        end
        start = 1'b0;
        check_output("ign_done_seen", int'(done), 1);
        check_output("ign_lat", lat, 5);
        check_output("ign_fitness", int'(fitness), 3);
        tick();
        check_output("ign_single_done", int'(done), 0);
        check_output("ign_not_busy", int'(busy), 0);
        tick();
        check_output("ign_still_idle", int'(busy), 0);

        // Reset in the middle of a sweep.
        chrom_in = 4'b0110; target_in = 4'b0110; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_output("mid_phen_inp", int'(phen_inp), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("mid_rst_busy", int'(busy), 0);
        check_output("mid_rst_phen_inp", int'(phen_inp), 0);
        check_output("mid_rst_fitness", int'(fitness), 0);
        check_output("mid_rst_done", int'(done), 0);
        check_output("mid_rst_chrom", int'(phen_chrom), 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_output("mid_rst_no_done", int'(done), 0);
        end
        apply_stimulus(vecs[2]);

        // Two-bit output build.
        run_out2(8'hA5, 8'hA5, 8, 1);
        run_out2(8'hA5, 8'hA4, 7, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fitness_eval_ctrl.md
Name: fitness_eval_ctrl

Overview:
- Serial fitness-evaluation sequencer for the genetic-circuit phenotype.
- On start, latches one chromosome and a target truth table.
- Holds the chromosome steady on the phenotype's configuration input and sweeps all 2^IN input vectors, one per clock.
- Compares each phenotype output word against the target and accumulates the count of matching output bits.
- Reports that count as the fitness, with a done pulse, to the evolutionary loop.

Parameters:
- IN, 4: phenotype input width; the sweep length is N = 2^IN vectors.
- OUT, 2: phenotype output width.
- CHROM_W, 64: chromosome width (matrix plus output-selection bits), passed through unchanged.
- TGT_W, OUT*2**IN (derived): target truth table width.
- FIT_W, $clog2(OUT*2**IN+1) (derived): fitness width.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous reset, active-high.
- start, input, 1: request evaluation; sampled only in IDLE or DONE.
- chrom_in, input, CHROM_W: chromosome to evaluate; latched when start is accepted.
- target_in, input, TGT_W: expected outputs. Vector v is at target_in[v*OUT +: OUT]. Latched when start is accepted.
- phen_chrom, output, CHROM_W: latched chromosome, driven to the phenotype's configuration input.
- phen_inp, output, IN: current input vector, driven to the phenotype.
- phen_out, input, OUT: phenotype output, treated as combinational from phen_chrom and phen_inp.
- busy, output, 1: high in EVAL and DRAIN.
- done, output, 1: one-cycle pulse when fitness is final.
- fitness, output, FIT_W: number of matching output bits over all vectors.
- perfect, output, 1: fitness == OUT*2^IN; valid with fitness.

Behaviour:
- Reset (synchronous, takes priority in every state, including mid-sweep):
  - state=IDLE.
  - phen_chrom=0, phen_inp=0.
  - busy=0, done=0, fitness=0, perfect=0.
  - accumulator, capture register and capture-valid flag cleared.
- States: IDLE, EVAL, DRAIN, DONE.
- IDLE / DONE with start=1, at accept edge E0:
  - latch chrom_in into phen_chrom and target_in into the target register.
  - phen_inp=0, accumulator=0, capture-valid=0.
  - next state EVAL.
  - fitness and perfect keep their previous values until the new result is written.
- DONE with start=0: return to IDLE. done is high only while in DONE (exactly one cycle).
- EVAL, at each edge:
  - capture {phen_out, phen_inp} into the capture stage, capture-valid=1.
  - if phen_inp==N-1, go to DRAIN and hold phen_inp; else phen_inp+=1.
- Accumulate stage, every edge with capture-valid=1:
  - accumulator += popcount(~(cap_out ^ tgt[cap_idx*OUT +: OUT])).
  - Match width is OUT; the sum never exceeds OUT*N, so FIT_W bits never overflow.
- DRAIN, one edge:
  - accumulates the last captured vector.
  - writes fitness = final sum, perfect = (final sum == OUT*N).
  - clears capture-valid; next state DONE.
- Latency: done is high during the cycle following edge E0+N+1. For IN=2 that is 5 edges after accept.
- Throughput: one vector per clock, back-to-back. A new start is accepted in the DONE cycle, so the next sweep begins with no idle gap.
- start is ignored while busy. chrom_in and target_in may change freely after accept.
- phen_chrom is stable from E0 until the next accept, so the phenotype settles for the full cycle before each capture.
- fitness and perfect hold after DONE until the next DRAIN write or reset.
- No wrap: phen_inp never exceeds N-1.

Test Plan:
All scenarios use IN=2, OUT=1, and a bench stub phenotype: phen_out = phen_chrom[phen_inp].
1. chrom=4'b0110, target=4'b0110, start 1 cycle -> phen_inp sequence 0,1,2,3; done 5 edges after accept; fitness=4; perfect=1; busy high for 4+1 cycles.
2. chrom=4'b0110, target=4'b1001 -> fitness=0, perfect=0. Then chrom=4'b0111, target=4'b0110 -> fitness=3.
3. Back-to-back: start held high continuously with alternating operands -> second sweep's phen_inp=0 in the cycle after done; results 4 then 0; no dropped vector.
4. start pulses during EVAL and DRAIN -> ignored; phen_chrom unchanged; single done pulse.
5. rst asserted at phen_inp=2 mid-sweep -> next cycle IDLE, busy=0, phen_inp=0, fitness=0, no done. A fresh start then gives a correct result.
6. OUT=2, IN=2: stub phen_out = phen_chrom[2*phen_inp +: 2], chrom=target=8'hA5 -> fitness=8, perfect=1. Flip one target bit -> fitness=7, perfect=0.
